// File: rtl/onehot_to_bin_enc.sv
// One-hot decimal to binary encoder with a single registered valid/ready stage.
// Multi-hot inputs are either flagged as errors (strict) or resolved to the highest line (priority).
module onehot_to_bin_enc #(
    parameter int N_IN     = 7,
    parameter int OUT_W    = $clog2(N_IN + 1),
    parameter bit PRIORITY = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N_IN-1:0]  i_dec,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_bin,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    input  logic             i_clr_cnt
);

    typedef struct packed {
        logic [OUT_W-1:0] code;
        logic             err;
    } enc_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Line k maps to code k+1; the ascending scan leaves the highest set line in hi.
    function automatic enc_t encode(input logic [N_IN-1:0] dec);
        enc_t             res;
        logic             seen;
        logic             multi;
        logic [OUT_W-1:0] hi;
        seen  = 1'b0;
        multi = 1'b0;
        hi    = {OUT_W{1'b0}};
        for (int k = 0; k < N_IN; k++) begin
            hi    = dec[k] ? OUT_W'(k + 1) : hi;
            multi = multi | (seen & dec[k]);
            seen  = seen | dec[k];
        end
        if (multi && (PRIORITY == 1'b0)) begin
            res.code = {OUT_W{1'b0}};
            res.err  = 1'b1;
        end else begin
            res.code = hi;
            res.err  = 1'b0;
        end
        return res;
    endfunction

    enc_t             enc_s;
    logic             accept_s;
    logic             valid_r;
    logic [OUT_W-1:0] bin_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    // Encode the incoming lines and decide whether this cycle transfers a word.
    always_comb begin
        enc_s    = encode(i_dec);
        accept_s = i_valid && o_ready;
    end

    // The stage may take a new word whenever it is empty or being drained.
    assign o_ready = !valid_r || i_ready;

    // Output stage: load on accept, drop valid once drained with nothing new behind it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            bin_r   <= {OUT_W{1'b0}};
            err_r   <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            bin_r   <= enc_s.code;
            err_r   <= enc_s.err;
        end else if (i_ready) begin
            valid_r <= 1'b0;
            bin_r   <= bin_r;
            err_r   <= err_r;
        end else begin
            valid_r <= valid_r;
            bin_r   <= bin_r;
            err_r   <= err_r;
        end
    end

    // Saturating illegal-input counter; a clear wins over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && enc_s.err && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_valid   = valid_r;
    assign o_bin     = bin_r;
    assign o_err     = err_r;
    assign o_err_cnt = cnt_r;

endmodule

// File: doc/onehot_to_bin_enc.md
Name: onehot_to_bin_enc

Overview:
- Parametrised, registered successor to the team's 7-line decimal-to-binary encoder.
- Converts an N_IN-line one-hot decimal input into a binary code through a single valid/ready pipeline stage.
- Supports strict-one-hot or priority encoding, flags illegal inputs, and keeps a saturating error count.
- Sits between keypad/selector front-ends and downstream binary consumers.

Parameters:
- N_IN, 7: number of decimal input lines; legal range 1..255.
- OUT_W, $clog2(N_IN+1): output code width. Derived; do not override.
- PRIORITY, 0: 0 = strict mode, where a multi-hot input is an error and encodes to 0. 1 = priority mode, where the highest set line wins and no error is raised.
- CNT_W, 8: width of the error counter.

Ports:
- i_clk, input, 1: clock; all logic is rising-edge.
- i_rst, input, 1: reset. One clock; reset is synchronous and active-high.
- i_valid, input, 1: upstream data valid.
- o_ready, output, 1: block can accept input this cycle.
- i_dec, input, N_IN: decimal lines. Bit k represents digit k+1.
- o_valid, output, 1: output code valid.
- i_ready, input, 1: downstream accepts output.
- o_bin, output, OUT_W: encoded value.
- o_err, output, 1: the held output came from an illegal (multi-hot) input.
- o_err_cnt, output, CNT_W: count of illegal inputs accepted.
- i_clr_cnt, input, 1: synchronous clear of o_err_cnt.

Behaviour:
- Reset:
  - While i_rst is high at a clock edge, o_valid=0, o_bin=0, o_err=0, o_err_cnt=0.
  - o_ready is combinational, so it reads 1 during reset.
  - Reset mid-transfer discards the held word; nothing is replayed.
- Encoding function (combinational, pre-register):
  - All-zero input → 0. This is legal and not an error.
  - Exactly one bit k set → k+1. For N_IN=7: bit0→1 … bit6→7.
  - Multi-hot input, PRIORITY=0 → code 0, err=1.
  - Multi-hot input, PRIORITY=1 → (index of highest set bit)+1, err=0.
- Handshake:
  - o_ready = !o_valid || i_ready.
  - Accept when i_valid && o_ready. On accept, o_bin, o_err and o_valid=1 register at the next edge.
  - Latency is 1 cycle. Throughput is 1 word per cycle while i_ready stays high.
  - When o_valid && !i_ready, o_bin and o_err hold stable and upstream is stalled.
  - When o_valid && i_ready && !i_valid, o_valid falls to 0 at the next edge; o_bin keeps its last value.
  - i_dec is ignored when not accepted.
- Error counter:
  - Increments by 1 on each accepted word whose err=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - i_clr_cnt has priority over an increment in the same cycle; the result is 0.
  - A held word stalled over multiple cycles is counted once, at accept only.
- No internal FSM beyond the valid register; a single output stage, with no skid buffer.

Test Plan:
- Reset then idle (N_IN=7, PRIORITY=0): after reset deasserts → o_valid=0, o_bin=0, o_err_cnt=0, o_ready=1.
- Sweep i_dec over 7'b000_0001, 7'b000_0010 … 7'b100_0000 with i_valid=1 and i_ready=1 → o_bin=1..7 one cycle later, back-to-back, o_err=0. i_dec=0 → o_bin=0, o_err=0.
- Strict multi-hot (PRIORITY=0): i_dec=7'b001_0100 accepted → o_bin=0, o_err=1, o_err_cnt=1. Same stimulus with PRIORITY=1 → o_bin=5, o_err=0, counter stays 0.
- Backpressure: accept 7'b000_1000, hold i_ready=0 for 3 cycles, present a new i_dec → o_ready=0, o_bin stays 4, o_valid stays 1. Raise i_ready → next word emerges 1 cycle later.
- Counter edge cases (CNT_W=2): 4 illegal accepts → o_err_cnt goes 1,2,3,3. An illegal accept concurrent with i_clr_cnt=1 → o_err_cnt=0.
- Wide config (N_IN=12, OUT_W=4): i_dec bit11 set → o_bin=12. Assert i_rst while o_valid=1 and i_ready=0 → next cycle o_valid=0, o_bin=0, o_err_cnt=0.
